stack_arbiter: RTL
==================

# stack_arbiter

Controller that shares one hardware return/data stack between two requesters (requester 0: core call/return path; requester 1: interrupt/context path). It owns the stack pointer and sequences a single-port synchronous stack memory with one-cycle read latency. It arbitrates push/pop requests round-robin over a req/ack handshake and reports overflow/underflow as sticky flags.

## Interface
- DATA_W, 32, stack word width
- DEPTH, 10, number of stack entries
- PTR_W, 4, pointer/count width; must satisfy 2^PTR_W > DEPTH
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req0_push, req0_pop  in  1 each  requester 0 operation request
- req0_data  in  DATA_W  requester 0 push data
- ack0  out  1  one-cycle completion pulse to requester 0
- req1_push, req1_pop, req1_data, ack1  same as requester 0, for requester 1
- err  out  1  pulses with ack when the acked operation was rejected
- rd_data  out  DATA_W  popped word, valid in the ack cycle of a pop
- count  out  PTR_W  current number of stored entries
- full, empty  out  1  count==DEPTH / count==0 (combinational from count)
- ovrflw, undrflw  out  1  sticky error flags, cleared only by rst
- mem_we  out  1  memory write enable
- mem_addr  out  PTR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address is presented

## Operation
- FSM states: IDLE, EXEC, RESP. IDLE -> EXEC when any request is present; EXEC -> RESP unconditionally; RESP -> IDLE unconditionally.
- IDLE: sample requests and register the winner, its op (push/pop) and its data. Request is present if push or pop is high.
- Arbitration: round-robin. If both requesters are present, grant the one not granted last. last_grant resets to 1, so requester 0 wins the first tie. last_grant updates only on a grant.
- Op decode for the winner: push only -> PUSH; pop only -> POP; push and pop both high -> ILLEGAL (rejected, no state change).
- EXEC, PUSH with count<DEPTH: mem_we=1, mem_addr=count, mem_wdata=data, count+1. Zero data is a legal push.
- EXEC, PUSH with count==DEPTH: no write, count unchanged, ovrflw set.
- EXEC, POP with count>0: mem_addr=count-1, count-1.
- EXEC, POP with count==0: no access, count unchanged, undrflw set.
- RESP: ack of the winner high for exactly one cycle. For a successful POP, rd_data <= mem_rdata. For a rejected op (overflow, underflow, ILLEGAL), err=1 and rd_data <= 0. rd_data otherwise holds its last value.
- mem_we is high only in EXEC of a successful PUSH and is forced 0 in any cycle where rst is high. mem_addr/mem_wdata hold their values outside EXEC.
- count never exceeds DEPTH and never wraps below 0.

## Timing
- Request seen in IDLE at cycle t: EXEC at t+1, memory read/write at t+1, ack/err/rd_data valid at t+2, IDLE at t+3.
- Peak throughput is one operation per 3 cycles. The losing requester is served in the next IDLE.
- Handshake: the requester holds push/pop/data stable until it sees ack. It must drop or change its request in the cycle after ack, which is the IDLE cycle. A request still high in that IDLE is a new operation.
- Requests that change while not in IDLE are ignored; the registered copy is used.
- Reset values: state=IDLE, count=0, last_grant=1, ack0=ack1=0, err=0, rd_data=0, mem_we=0, mem_addr=0, mem_wdata=0, ovrflw=0, undrflw=0.
- rst in EXEC or RESP aborts the operation: no ack is issued and count returns to 0. Stack contents are treated as discarded.

## Test plan
- Reset, then req0 pushes 0xA, 0xB, 0xC, then pops 3 times -> each ack 2 cycles after request; rd_data 0xC, 0xB, 0xA; count 3->0; err=0; empty=1.
- Push 10 words (1..10), then push 0x55 -> full=1 after the 10th; 11th ack has err=1, ovrflw=1 sticky, no mem_we, count=10; a pop returns 10.
- Pop on empty stack -> ack with err=1, rd_data=0, undrflw=1, count=0; the flag persists until rst.
- req0 and req1 push continuously (0x100+n and 0x200+n) -> grants alternate 0,1,0,1 starting with req0; memory holds interleaved values; no ack is lost.
- req1 asserts push and pop together -> ack1 with err=1, count unchanged, no mem_we, ovrflw/undrflw unchanged.
- Assert rst during EXEC of a push with count=5 -> no ack, mem_we=0 in the rst cycle, count=0 and all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/stack_arbiter.sv
// Shares one synchronous single-port stack memory between two requesters.
// Round-robin arbitration, IDLE/EXEC/RESP sequencing, sticky overflow/underflow flags.
module stack_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_push,
  input  logic              req0_pop,
  input  logic [DATA_W-1:0] req0_data,
  output logic              ack0,
  input  logic              req1_push,
  input  logic              req1_pop,
  input  logic [DATA_W-1:0] req1_data,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovrflw,
  output logic              undrflw,
  output logic              mem_we,
  output logic [PTR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state_o
);
  // Handshake: a requester holds push/pop/data until its one-cycle ack; the
  // request is sampled only in IDLE, so anything still high there is a new op.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OP_PUSH = 2'd0, OP_POP = 2'd1, OP_ILL = 2'd2} op_t;

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic              rej_q, rej_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  addr_q, addr_d;
  logic              p0, p1, gnt, w_push, w_pop;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    win_d   = win_q;
    last_d  = last_q;
    rej_d   = rej_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    count_d = count_q;
    addr_d  = addr_q;
    mem_we  = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    err     = 1'b0;
    p0      = req0_push | req0_pop;
    p1      = req1_push | req1_pop;
    gnt     = (p0 && p1) ? ~last_q : p1;
    w_push  = gnt ? req1_push : req0_push;
    w_pop   = gnt ? req1_pop  : req0_pop;
    case (state_q)
      IDLE: begin
        if (p0 || p1) begin
          win_d   = gnt;
          last_d  = gnt;
          data_d  = gnt ? req1_data : req0_data;
          op_d    = (w_push && w_pop) ? OP_ILL : (w_push ? OP_PUSH : OP_POP);
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        rej_d   = 1'b0;
        case (op_q)
          OP_PUSH: begin
            if (count_q < DEPTH_P) begin
              mem_we  = 1'b1;
              addr_d  = count_q;
              wdata_d = data_q;
              count_d = count_q + ONE_P;
            end else begin
              rej_d = 1'b1;
              ovf_d = 1'b1;
            end
          end
          OP_POP: begin
            if (count_q != '0) begin
              addr_d  = count_q - ONE_P;
              count_d = count_q - ONE_P;
            end else begin
              rej_d = 1'b1;
              udf_d = 1'b1;
            end
          end
          default: rej_d = 1'b1;
        endcase
      end
      RESP: begin
        state_d = IDLE;
        ack0    = ~win_q;
        ack1    = win_q;
        err     = rej_q;
        if (rej_q) rd_d = '0;
        else if (op_q == OP_POP) rd_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts whatever is in flight: no write, no completion.
    if (rst) begin
      mem_we = 1'b0;
      ack0   = 1'b0;
      ack1   = 1'b0;
      err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_PUSH;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      rej_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      win_q   <= win_d;
      last_q  <= last_d;
      rej_q   <= rej_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  assign rd_data     = rd_d;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_P);
  assign empty       = (count_q == '0);
  assign ovrflw      = ovf_q;
  assign undrflw     = udf_q;
  assign mem_addr    = addr_d;
  assign mem_wdata   = wdata_d;
  assign dbg_state_o = state_q;
endmodule
